// File: rtl/spi_controlador_transacao.sv
// rtl/spi_controlador_transacao.sv - multi-byte SPI transaction sequencer with chip-select guard times
module spi_controlador_transacao #(
   parameter int  NUM_CS       = 4,
   parameter int  CICLOS_SETUP = 4,
   parameter int  CICLOS_HOLD  = 4,
   localparam int CS_W         = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
   localparam int CNT_MAX      = (CICLOS_SETUP > CICLOS_HOLD) ? CICLOS_SETUP : CICLOS_HOLD,
   localparam int CNT_W        = $clog2(CNT_MAX + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valido,
   output logic              cmd_pronto,
   input  logic [CS_W-1:0]   cmd_cs,
   input  logic [7:0]        cmd_num_bytes,
   input  logic              abortar,
   input  logic [7:0]        in_dado,
   input  logic              in_valido,
   output logic              in_pronto,
   output logic [7:0]        out_dado,
   output logic              out_valido,
   output logic              fim,
   output logic              abortado,
   output logic [7:0]        eng_tx_dado,
   output logic              eng_tx_valido,
   input  logic              eng_tx_pronto,
   input  logic [7:0]        eng_rx_dado,
   input  logic              eng_rx_valido,
   output logic [NUM_CS-1:0] spi_cs_n
);

   typedef enum logic [2:0] {
      OCIOSO,
      SETUP,
      ENVIA,
      ESPERA,
      HOLD
   } estado_t;

   estado_t           estado_q, estado_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        restante_q, restante_d;
   logic              abort_pend_q, abort_pend_d;
   logic              abortado_q, abortado_d;
   logic              fim_q, fim_d;
   logic              out_valido_q, out_valido_d;
   logic [7:0]        out_dado_q, out_dado_d;
   logic [NUM_CS-1:0] cs_n_q, cs_n_d;
   logic              entrega;

   assign cmd_pronto    = (estado_q == OCIOSO);
   assign in_pronto     = (estado_q == ENVIA) & eng_tx_pronto & ~abortar;
   assign eng_tx_valido = (estado_q == ENVIA) & in_valido & ~abortar;
   assign eng_tx_dado   = in_dado;
   assign entrega       = eng_tx_valido & eng_tx_pronto;

   assign out_dado   = out_dado_q;
   assign out_valido = out_valido_q;
   assign fim        = fim_q;
   assign abortado   = abortado_q;
   assign spi_cs_n   = cs_n_q;

   // Next-state logic: sequences setup guard, byte exchange loop and hold guard
   always_comb begin
      estado_d     = estado_q;
      cnt_d        = cnt_q;
      restante_d   = restante_q;
      abort_pend_d = abort_pend_q;
      abortado_d   = fim_q ? 1'b0 : abortado_q;
      fim_d        = 1'b0;
      out_valido_d = 1'b0;
      out_dado_d   = out_dado_q;
      cs_n_d       = cs_n_q;

      case (estado_q)
         OCIOSO: begin
            abort_pend_d = 1'b0;
            if (cmd_valido) begin
               restante_d = cmd_num_bytes;
               cnt_d      = CNT_W'(CICLOS_SETUP);
               // An out-of-range index matches no line, so every select stays high
               cs_n_d     = '1;
               for (int i = 0; i < NUM_CS; i++) begin
                  if (cmd_cs == CS_W'(i)) cs_n_d[i] = 1'b0;
               end
               estado_d   = SETUP;
            end
         end
         SETUP: begin
            if (abortar) begin
               cnt_d      = CNT_W'(CICLOS_HOLD);
               abortado_d = 1'b1;
               estado_d   = HOLD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) estado_d = ENVIA;
            end
         end
         ENVIA: begin
            if (abortar) begin
               cnt_d      = CNT_W'(CICLOS_HOLD);
               abortado_d = 1'b1;
               estado_d   = HOLD;
            end else if (entrega) begin
               estado_d = ESPERA;
            end
         end
         ESPERA: begin
            // The byte on the wire must finish; remember an abort until it does
            if (abortar) abort_pend_d = 1'b1;
            if (eng_rx_valido) begin
               out_dado_d   = eng_rx_dado;
               out_valido_d = 1'b1;
               restante_d   = restante_q - 8'd1;
               if (abortar || abort_pend_q || (restante_q == 8'd1)) begin
                  cnt_d    = CNT_W'(CICLOS_HOLD);
                  estado_d = HOLD;
                  if (abortar || abort_pend_q) abortado_d = 1'b1;
               end else begin
                  estado_d = ENVIA;
               end
            end
         end
         HOLD: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               cs_n_d   = '1;
               fim_d    = 1'b1;
               estado_d = OCIOSO;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   // State and output registers; reset releases every chip select at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q     <= OCIOSO;
         cnt_q        <= '0;
         restante_q   <= '0;
         abort_pend_q <= 1'b0;
         abortado_q   <= 1'b0;
         fim_q        <= 1'b0;
         out_valido_q <= 1'b0;
         out_dado_q   <= '0;
         cs_n_q       <= '1;
      end else begin
         estado_q     <= estado_d;
         cnt_q        <= cnt_d;
         restante_q   <= restante_d;
         abort_pend_q <= abort_pend_d;
         abortado_q   <= abortado_d;
         fim_q        <= fim_d;
         out_valido_q <= out_valido_d;
         out_dado_q   <= out_dado_d;
         cs_n_q       <= cs_n_d;
      end
   end

endmodule

// File: tb/tb_spi_controlador_transacao.sv
// tb/tb_spi_controlador_transacao.sv - self-checking bench for spi_controlador_transacao
module tb_spi_controlador_transacao;

   localparam int NUM_CS = 4;
   localparam int SETUP  = 4;
   localparam int HOLD   = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valido, cmd_pronto;
   logic [1:0] cmd_cs;
   logic [7:0] cmd_num_bytes;
   logic       abortar;
   logic [7:0] in_dado;
   logic       in_valido, in_pronto;
   logic [7:0] out_dado;
   logic       out_valido, fim, abortado;
   logic [7:0] eng_tx_dado;
   logic       eng_tx_valido, eng_tx_pronto;
   logic [7:0] eng_rx_dado;
   logic       eng_rx_valido;
   logic [3:0] spi_cs_n;

   int checks = 0;
   int errors = 0;

   // monitor-owned observations
   int         cyc = 0, tx_cnt = 0, acc_cnt = 0, fim_cnt = 0;
   int         acc_cyc = 0, last_tx_cyc = 0, last_rx_cyc = 0, fim_cyc = 0;
   logic       fim_ab = 1'b0;
   logic [3:0] cs_at_fim = 4'h0;
   logic [7:0] rx_q[$];

   // stimulus-owned state
   logic [7:0] feed_mem[0:2047];
   int         feed_wr = 0, feed_skip = 0, feed_rd = 0;
   bit         feed_hold = 1'b0, feed_rand = 1'b1, eng_block = 1'b0;
   logic [7:0] eng_xor = 8'h00;
   logic [7:0] exp_q[$];
   int         rx_base = 0, base_tx = 0, base_fim = 0;

   always #5 clk = ~clk;

   spi_controlador_transacao #(
      .NUM_CS(NUM_CS), .CICLOS_SETUP(SETUP), .CICLOS_HOLD(HOLD)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valido(cmd_valido), .cmd_pronto(cmd_pronto), .cmd_cs(cmd_cs),
      .cmd_num_bytes(cmd_num_bytes), .abortar(abortar),
      .in_dado(in_dado), .in_valido(in_valido), .in_pronto(in_pronto),
      .out_dado(out_dado), .out_valido(out_valido), .fim(fim), .abortado(abortado),
      .eng_tx_dado(eng_tx_dado), .eng_tx_valido(eng_tx_valido), .eng_tx_pronto(eng_tx_pronto),
      .eng_rx_dado(eng_rx_dado), .eng_rx_valido(eng_rx_valido), .spi_cs_n(spi_cs_n)
   );

   // edge-sampled event log
   always @(posedge clk) begin
      cyc++;
      if (cmd_valido && cmd_pronto) begin acc_cnt++; acc_cyc = cyc; end
      if (eng_tx_valido && eng_tx_pronto) begin tx_cnt++; last_tx_cyc = cyc; end
      if (eng_rx_valido) last_rx_cyc = cyc;
   end

   // output stream log, sampled mid-cycle
   always @(negedge clk) begin
      if (out_valido) rx_q.push_back(out_dado);
      if (fim) begin fim_cnt++; fim_cyc = cyc; fim_ab = abortado; cs_at_fim = spi_cs_n; end
   end

   // byte engine model: takes one byte, answers it xor eng_xor after 1..4 cycles
   initial begin
      logic [7:0] b;
      int lat;
      eng_rx_valido = 1'b0; eng_rx_dado = 8'h00; eng_tx_pronto = 1'b1;
      forever begin
         @(posedge clk);
         if (eng_tx_valido && eng_tx_pronto) begin
            b   = eng_tx_dado ^ eng_xor;
            lat = $urandom_range(1, 4);
            #1 eng_tx_pronto = 1'b0;
            repeat (lat) @(posedge clk);
            #1 eng_rx_dado = b;
            eng_rx_valido = 1'b1;
            @(posedge clk);
            #1 eng_rx_valido = 1'b0;
            eng_tx_pronto = !eng_block;
         end else begin
            #1 eng_tx_pronto = !eng_block;
         end
      end
   end

   // requester model: presents queued bytes with optional random gaps
   initial begin
      in_valido = 1'b0; in_dado = 8'h00;
      forever begin
         @(posedge clk);
         if (in_valido && in_pronto) feed_rd++;
         if (feed_rd < feed_skip) feed_rd = feed_skip;
         #1;
         if (feed_rd < feed_wr && !feed_hold && (!feed_rand || $urandom_range(0, 3) != 0)) begin
            in_valido = 1'b1; in_dado = feed_mem[feed_rd];
         end else begin
            in_valido = 1'b0; in_dado = 8'($urandom);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
      $fatal(1);
   end

   function automatic logic [3:0] cs_pat(input int cs);
      logic [3:0] one = 4'b0001;
      return ~(one << cs);
   endfunction

   function automatic int data_errs(input int n);
      int bad = 0;
      for (int i = 0; i < n; i++)
         if (rx_base + i >= rx_q.size() || rx_q[rx_base + i] !== exp_q[i]) bad++;
      return bad;
   endfunction

   task automatic prep(input logic [7:0] mask, input bit rnd);
      exp_q.delete();
      rx_base   = rx_q.size();
      eng_xor   = mask;
      feed_rand = rnd;
      feed_skip = feed_wr;
      base_tx   = tx_cnt;
      base_fim  = fim_cnt;
   endtask

   task automatic feed_byte(input logic [7:0] b);
      feed_mem[feed_wr] = b;
      feed_wr++;
      exp_q.push_back(b ^ eng_xor);
   endtask

   task automatic start_txn(input int cs, input int n);
      bit ok = 1'b0;
      @(posedge clk); #2;
      cmd_valido = 1'b1; cmd_cs = 2'(cs); cmd_num_bytes = 8'(n);
      for (int w = 0; w < 100; w++) begin
         @(posedge clk);
         if (cmd_pronto) begin ok = 1'b1; break; end
      end
      #2 cmd_valido = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL cmd_accept: command not accepted within 100 cycles"); end
   endtask

   task automatic wait_fim(input int bound, input logic [3:0] exp_cs, output int cs_bad, output bit ok);
      cs_bad = 0; ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (fim) begin ok = 1'b1; break; end
         if (spi_cs_n !== exp_cs) cs_bad++;
      end
      #1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (spi_cs_n !== 4'hF) begin errors++; $display("FAIL reset_cs: got %h expected f", spi_cs_n); end
      checks++; if (out_valido !== 1'b0) begin errors++; $display("FAIL reset_out_valido: got %b expected 0", out_valido); end
      checks++; if (out_dado !== 8'h00) begin errors++; $display("FAIL reset_out_dado: got %h expected 00", out_dado); end
      checks++; if (fim !== 1'b0 || abortado !== 1'b0) begin errors++; $display("FAIL reset_fim: got fim=%b abortado=%b expected 0 0", fim, abortado); end
      checks++; if (cmd_pronto !== 1'b1) begin errors++; $display("FAIL reset_cmd_pronto: got %b expected 1", cmd_pronto); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_byte();
      int cs_bad; bit ok;
      prep(8'h99, 1'b0);
      feed_byte(8'hA5);
      start_txn(2, 1);
      wait_fim(200, 4'b1011, cs_bad, ok);
      repeat (2) @(negedge clk);
      checks++; if (!ok) begin errors++; $display("FAIL single_fim: no fim within 200 cycles"); end
      checks++; if (cs_bad != 0) begin errors++; $display("FAIL single_cs: %0d cycles with cs_n not 1011", cs_bad); end
      checks++; if (rx_q.size() - rx_base != 1) begin errors++; $display("FAIL single_count: got %0d bytes expected 1", rx_q.size() - rx_base); end
      checks++; if (rx_q[rx_base] !== 8'h3C) begin errors++; $display("FAIL single_data: got %h expected 3c", rx_q[rx_base]); end
      checks++; if (fim_ab !== 1'b0) begin errors++; $display("FAIL single_abortado: got %b expected 0", fim_ab); end
      checks++; if (cs_at_fim !== 4'hF) begin errors++; $display("FAIL single_cs_at_fim: got %h expected f", cs_at_fim); end
      checks++; if (last_tx_cyc - acc_cyc != SETUP + 1) begin errors++; $display("FAIL single_setup_time: got %0d expected %0d", last_tx_cyc - acc_cyc, SETUP + 1); end
      checks++; if (fim_cyc - last_rx_cyc != HOLD) begin errors++; $display("FAIL single_hold_time: got %0d expected %0d", fim_cyc - last_rx_cyc, HOLD); end
      checks++; if (fim_cnt - base_fim != 1) begin errors++; $display("FAIL single_fim_count: got %0d expected 1", fim_cnt - base_fim); end
   endtask

   task automatic test_four_bytes();
      int cs_bad; bit ok; int cs;
      cs = $urandom_range(0, 3);
      prep(8'h00, 1'b1);
      for (int i = 1; i <= 4; i++) feed_byte(8'(i));
      start_txn(cs, 4);
      wait_fim(300, cs_pat(cs), cs_bad, ok);
      repeat (3) @(negedge clk);
      checks++; if (!ok || cs_bad != 0) begin errors++; $display("FAIL four_cs: fim_seen=%0d cs_bad=%0d expected 1 0", ok, cs_bad); end
      checks++; if (rx_q.size() - rx_base != 4 || data_errs(4) != 0) begin errors++; $display("FAIL four_data: got %0d bytes, %0d wrong, expected 4 bytes 01..04", rx_q.size() - rx_base, data_errs(4)); end
      checks++; if (fim_cnt - base_fim != 1) begin errors++; $display("FAIL four_fim_count: got %0d expected 1", fim_cnt - base_fim); end
      checks++; if (fim_ab !== 1'b0) begin errors++; $display("FAIL four_abortado: got %b expected 0", fim_ab); end
   endtask

   task automatic test_random();
      int cs_bad; bit ok; int cs, n;
      for (int t = 0; t < 3; t++) begin
         cs = $urandom_range(0, 3);
         n  = $urandom_range(1, 8);
         prep(8'($urandom), 1'b1);
         for (int i = 0; i < n; i++) feed_byte(8'($urandom));
         start_txn(cs, n);
         wait_fim(500, cs_pat(cs), cs_bad, ok);
         checks++; if (!ok || cs_bad != 0) begin errors++; $display("FAIL rand_cs[%0d]: fim_seen=%0d cs_bad=%0d expected 1 0", t, ok, cs_bad); end
         checks++; if (rx_q.size() - rx_base != n || data_errs(n) != 0) begin errors++; $display("FAIL rand_data[%0d]: got %0d bytes, %0d wrong, expected %0d", t, rx_q.size() - rx_base, data_errs(n), n); end
         checks++; if (tx_cnt - base_tx != n) begin errors++; $display("FAIL rand_tx_count[%0d]: got %0d expected %0d", t, tx_cnt - base_tx, n); end
      end
   endtask

   task automatic test_n_zero();
      int cs_bad; bit ok; int f;
      prep(8'h00, 1'b1);
      for (int i = 0; i < 256; i++) feed_byte(8'(i));
      feed_byte(8'h5A);
      start_txn(0, 0);
      cmd_valido = 1'b1; cmd_cs = 2'd1; cmd_num_bytes = 8'd1;
      wait_fim(6000, 4'b1110, cs_bad, ok);
      f = fim_cyc;
      checks++; if (!ok || cs_bad != 0) begin errors++; $display("FAIL n0_cs: fim_seen=%0d cs_bad=%0d expected 1 0", ok, cs_bad); end
      checks++; if (rx_q.size() - rx_base != 256 || data_errs(256) != 0) begin errors++; $display("FAIL n0_data: got %0d bytes, %0d wrong, expected 256", rx_q.size() - rx_base, data_errs(256)); end
      checks++; if (cs_at_fim !== 4'hF) begin errors++; $display("FAIL n0_cs_at_fim: got %h expected f", cs_at_fim); end
      @(posedge clk); #2 cmd_valido = 1'b0;
      checks++; if (acc_cyc != f + 1) begin errors++; $display("FAIL n0_back_to_back: accepted at edge %0d expected %0d", acc_cyc, f + 1); end
      wait_fim(200, 4'b1101, cs_bad, ok);
      checks++; if (!ok || cs_bad != 0 || rx_q.size() - rx_base != 257 || data_errs(257) != 0) begin errors++; $display("FAIL n0_second: fim_seen=%0d cs_bad=%0d bytes=%0d expected 1 0 257", ok, cs_bad, rx_q.size() - rx_base); end
   endtask

   task automatic test_abort_setup();
      int cs_bad; bit ok; int a;
      prep(8'h00, 1'b0);
      for (int i = 0; i < 3; i++) feed_byte(8'($urandom));
      start_txn(3, 3);
      abortar = 1'b1;
      a = acc_cyc + 1;
      @(posedge clk); #2 abortar = 1'b0;
      wait_fim(100, 4'b0111, cs_bad, ok);
      checks++; if (!ok || fim_cyc - a != HOLD) begin errors++; $display("FAIL abort_setup_time: fim_seen=%0d delay=%0d expected %0d", ok, fim_cyc - a, HOLD); end
      checks++; if (fim_ab !== 1'b1) begin errors++; $display("FAIL abort_setup_abortado: got %b expected 1", fim_ab); end
      checks++; if (tx_cnt != base_tx || rx_q.size() != rx_base) begin errors++; $display("FAIL abort_setup_traffic: tx=%0d rx=%0d expected 0 0", tx_cnt - base_tx, rx_q.size() - rx_base); end
      @(negedge clk);
      checks++; if (abortado !== 1'b0) begin errors++; $display("FAIL abort_setup_clear: got %b expected 0", abortado); end
   endtask

   task automatic test_abort_espera();
      int cs_bad; bit ok = 1'b0;
      prep(8'($urandom), 1'b0);
      for (int i = 0; i < 5; i++) feed_byte(8'($urandom));
      start_txn(1, 5);
      for (int w = 0; w < 200; w++) begin
         @(posedge clk); #2;
         if (tx_cnt - base_tx == 2) begin ok = 1'b1; break; end
      end
      abortar = 1'b1;
      @(posedge clk); #2 abortar = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL abort_espera_reach: second byte not handed off"); end
      wait_fim(200, 4'b1101, cs_bad, ok);
      repeat (2) @(negedge clk);
      checks++; if (!ok || cs_bad != 0) begin errors++; $display("FAIL abort_espera_cs: fim_seen=%0d cs_bad=%0d expected 1 0", ok, cs_bad); end
      checks++; if (rx_q.size() - rx_base != 2 || data_errs(2) != 0) begin errors++; $display("FAIL abort_espera_data: got %0d bytes, %0d wrong, expected 2", rx_q.size() - rx_base, data_errs(2)); end
      checks++; if (tx_cnt - base_tx != 2) begin errors++; $display("FAIL abort_espera_tx: got %0d expected 2", tx_cnt - base_tx); end
      checks++; if (fim_ab !== 1'b1) begin errors++; $display("FAIL abort_espera_abortado: got %b expected 1", fim_ab); end
   endtask

   task automatic test_backpressure();
      int cs_bad; bit ok; int bp_bad = 0;
      prep(8'h00, 1'b0);
      feed_hold = 1'b1;
      feed_byte(8'($urandom)); feed_byte(8'($urandom));
      start_txn(2, 2);
      repeat (SETUP + 11) @(negedge clk);
      checks++; if (tx_cnt != base_tx || spi_cs_n !== 4'b1011 || cmd_pronto !== 1'b0) begin errors++; $display("FAIL bp_in_valido: tx=%0d cs_n=%h cmd_pronto=%b expected 0 b 0", tx_cnt - base_tx, spi_cs_n, cmd_pronto); end
      eng_block = 1'b1; feed_hold = 1'b0;
      @(posedge clk); #2;
      repeat (5) begin
         @(negedge clk);
         if (eng_tx_valido !== 1'b1 || in_pronto !== 1'b0 || spi_cs_n !== 4'b1011) bp_bad++;
      end
      checks++; if (bp_bad != 0 || tx_cnt != base_tx) begin errors++; $display("FAIL bp_eng_pronto: bad_cycles=%0d tx=%0d expected 0 0", bp_bad, tx_cnt - base_tx); end
      eng_block = 1'b0;
      wait_fim(300, 4'b1011, cs_bad, ok);
      checks++; if (!ok || cs_bad != 0 || rx_q.size() - rx_base != 2 || data_errs(2) != 0) begin errors++; $display("FAIL bp_complete: fim_seen=%0d cs_bad=%0d bytes=%0d expected 1 0 2", ok, cs_bad, rx_q.size() - rx_base); end
   endtask

   task automatic test_reset_mid();
      int cs_bad; bit ok = 1'b0; int fims;
      prep(8'h00, 1'b1);
      for (int i = 0; i < 3; i++) feed_byte(8'($urandom));
      start_txn(3, 3);
      for (int w = 0; w < 200; w++) begin
         @(posedge clk); #2;
         if (tx_cnt - base_tx == 2) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL rst_reach: second byte not handed off"); end
      fims = fim_cnt;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (spi_cs_n !== 4'hF || cmd_pronto !== 1'b1) begin errors++; $display("FAIL rst_async: cs_n=%h cmd_pronto=%b expected f 1", spi_cs_n, cmd_pronto); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (fim_cnt != fims || rx_q.size() - rx_base != 1 || spi_cs_n !== 4'hF) begin errors++; $display("FAIL rst_quiet: fims=%0d bytes=%0d cs_n=%h expected 0 1 f", fim_cnt - fims, rx_q.size() - rx_base, spi_cs_n); end
      prep(8'($urandom), 1'b1);
      feed_byte(8'($urandom)); feed_byte(8'($urandom));
      start_txn(0, 2);
      wait_fim(300, 4'b1110, cs_bad, ok);
      checks++; if (!ok || cs_bad != 0 || rx_q.size() - rx_base != 2 || data_errs(2) != 0 || fim_ab !== 1'b0) begin errors++; $display("FAIL rst_after: fim_seen=%0d cs_bad=%0d bytes=%0d abortado=%b expected 1 0 2 0", ok, cs_bad, rx_q.size() - rx_base, fim_ab); end
   endtask

   initial begin
      cmd_valido = 1'b0; cmd_cs = 2'd0; cmd_num_bytes = 8'd0; abortar = 1'b0;
      test_reset();
      test_single_byte();
      test_four_bytes();
      test_random();
      test_n_zero();
      test_abort_setup();
      test_abort_espera();
      test_backpressure();
      test_reset_mid();
      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
